dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4 -- consecutive denied accelerator-request cycles before the accelerator is forced to win (range 1..15).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 cpu_req  in  1  CPU memory-stage access request (MemwriteM or load in flight).
REQ-005 cpu_we  in  1  CPU write enable (1 = store, 0 = load).
REQ-006 cpu_addr  in  16  CPU byte address (ALU result).
REQ-007 cpu_wdata  in  16  CPU store data.
REQ-008 cpu_stall  out  1  CPU request not granted this cycle; hold memory stage.
REQ-009 cpu_rdata  out  16  CPU load data.
REQ-010 cpu_rvalid  out  1  cpu_rdata valid this cycle.
REQ-011 acc_req, acc_we  in  1 each  accelerator (crypto/FPU DMA) request and write enable.
REQ-012 acc_addr, acc_wdata  in  16 each  accelerator address and store data.
REQ-013 acc_gnt  out  1  accelerator request accepted this cycle.
REQ-014 acc_rdata  out  16;  acc_rvalid  out  1  accelerator load data and its valid.
REQ-015 mem_en, mem_we  out  1 each  single-port data memory enable and write enable.
REQ-016 mem_addr, mem_wdata  out  16 each  memory address and write data.
REQ-017 mem_rdata  in  16  memory read data; synchronous, valid the cycle after a read issue.

Function
REQ-018 The block shall issue at most one memory access per cycle.
REQ-019 Grant shall be combinational in the request cycle: the winner's we/addr/wdata drive mem_*, and mem_en = 1.
REQ-020 No request: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-021 Default priority: CPU wins when cpu_req = 1 and starve_cnt < STARVE_MAX.
REQ-022 starve_cnt (4-bit) shall increment, saturating at STARVE_MAX, each cycle acc_req = 1 and acc_gnt = 0; it shall clear on acc_gnt = 1 or acc_req = 0.
REQ-023 When starve_cnt = STARVE_MAX and acc_req = 1, the accelerator shall win over a simultaneous cpu_req.
REQ-024 cpu_stall = cpu_req AND NOT CPU granted; acc_gnt = acc_req AND accelerator granted.
REQ-025 Requesters shall hold req/we/addr/wdata stable until granted; the arbiter does not buffer requests.
REQ-026 A read owner register (NONE/CPU/ACC) shall capture the owner of each granted read (we = 0); writes set NONE.
REQ-027 The cycle after a CPU read grant: cpu_rvalid = 1 and cpu_rdata = mem_rdata; likewise acc_rvalid/acc_rdata for ACC. Read latency is exactly 1 cycle.
REQ-028 When not valid, *_rdata shall be 16'h0000.
REQ-029 Back-to-back reads by alternating owners shall each return to the correct owner; full throughput is one access per cycle.
REQ-030 A write is complete on the grant edge; no response is generated.

Reset
REQ-031 rst = 0 shall immediately force: read owner NONE, starve_cnt 0, cpu_rvalid 0, acc_rvalid 0, acc_gnt 0, cpu_stall 0, all mem_* 0, all rdata 0.
REQ-032 A read granted in the cycle before reset assertion shall return no rvalid.
REQ-033 Arbitration shall resume on the first rising clk edge after rst deasserts.

Verification
REQ-034 CPU only: cpu_req = 1, cpu_we = 0, addr 16'h0010, mem holds 16'hBEEF -> cpu_stall 0, next cycle cpu_rvalid 1, cpu_rdata 16'hBEEF.
REQ-035 Contention: both request continuously, STARVE_MAX = 4 -> CPU granted cycles 0-3 with acc_gnt 0; cycle 4 acc_gnt 1, cpu_stall 1; starve_cnt back to 0.
REQ-036 Alternating reads: CPU read at 16'h0002 (16'h1111), then ACC read at 16'h0004 (16'h2222) -> cpu_rvalid with 16'h1111, then acc_rvalid with 16'h2222, never both in one cycle.
REQ-037 Write then read: ACC write 16'hA5A5 to 16'h0020, then CPU read of 16'h0020 -> cpu_rdata 16'hA5A5, no rvalid for the write.
REQ-038 Reset mid-read: CPU read granted, rst low before the next edge -> cpu_rvalid stays 0 and all outputs 0 while rst = 0.
REQ-039 acc_req dropped at starve_cnt 3 and reasserted -> count restarts from 0; CPU keeps priority for 4 more cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data memory: CPU has default
// priority, the accelerator is forced through after STARVE_MAX denied cycles.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        acc_req,
    input  logic        acc_we,
    input  logic [15:0] acc_addr,
    input  logic [15:0] acc_wdata,
    output logic        acc_gnt,
    output logic [15:0] acc_rdata,
    output logic        acc_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_ACC  = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       cpu_win_s;
    logic       acc_win_s;
    logic [3:0] starve_q;
    logic [3:0] starve_d;
    owner_e     owner_q;
    owner_e     owner_d;

    // Winner selection; everything is suppressed while reset is held low.
    always_comb begin
        cpu_win_s = 1'b0;
        acc_win_s = 1'b0;
        if (rst) begin
            acc_win_s = acc_req && (!cpu_req || (starve_q >= STARVE_LIM));
            cpu_win_s = cpu_req && !acc_win_s;
        end else begin
            cpu_win_s = 1'b0;
            acc_win_s = 1'b0;
        end
    end

    // Memory port mux and request-side handshakes.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (cpu_win_s) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (acc_win_s) begin
            mem_en    = 1'b1;
            mem_we    = acc_we;
            mem_addr  = acc_addr;
            mem_wdata = acc_wdata;
        end else begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = 16'h0000;
            mem_wdata = 16'h0000;
        end
        cpu_stall = rst && cpu_req && !cpu_win_s;
        acc_gnt   = acc_win_s;
    end

    // Next-state for the starvation counter and the pending read owner.
    always_comb begin
        starve_d = 4'd0;
        owner_d  = OWN_NONE;
        if (acc_req && !acc_win_s) begin
            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : (starve_q + 4'd1);
        end else begin
            starve_d = 4'd0;
        end
        if (cpu_win_s && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (acc_win_s && !acc_we) begin
            owner_d = OWN_ACC;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Registered arbitration state; async reset drops any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= 4'd0;
            owner_q  <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // Route the one-cycle-late memory data to whichever master issued the read.
    always_comb begin
        cpu_rvalid = 1'b0;
        acc_rvalid = 1'b0;
        cpu_rdata  = 16'h0000;
        acc_rdata  = 16'h0000;
        if (rst) begin
            case (owner_q)
                OWN_CPU: begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = mem_rdata;
                end
                OWN_ACC: begin
                    acc_rvalid = 1'b1;
                    acc_rdata  = mem_rdata;
                end
                default: begin
                    cpu_rvalid = 1'b0;
                    acc_rvalid = 1'b0;
                end
            endcase
        end else begin
            cpu_rvalid = 1'b0;
            acc_rvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level
// model of the arbitration rules and a reference copy of memory.
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, acc_req, acc_we;
    logic [15:0] cpu_addr, cpu_wdata, acc_addr, acc_wdata;
    logic        cpu_stall, cpu_rvalid, acc_gnt, acc_rvalid;
    logic [15:0] cpu_rdata, acc_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] tb_mem [256];

    int          n_checks = 0;
    int          n_pass   = 0;

    // model state
    int          waited;
    int          pend_owner;
    logic [15:0] pend_data;
    logic [15:0] ref_mem [256];
    logic        last_cpu_win, last_acc_win;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_gnt(acc_gnt), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory; garbage on the read bus when no read was issued.
    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_addr] <= pl_data;
        else if (mem_en && mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr[7:0]];
        else mem_rdata <= 16'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        waited     = 0;
        pend_owner = 0;
        pend_data  = 16'h0000;
    endtask

    // Compare every output against the model, then advance the model one transaction.
    task automatic check_cycle();
        logic        a_win, c_win, e_en, e_we;
        logic [15:0] e_addr, e_wd;
        a_win = acc_req && (!cpu_req || waited >= SM);
        c_win = cpu_req && !a_win;
        e_en  = a_win || c_win;
        e_we  = c_win ? cpu_we : (a_win ? acc_we : 1'b0);
        e_addr = c_win ? cpu_addr : (a_win ? acc_addr : 16'h0000);
        e_wd   = c_win ? cpu_wdata : (a_win ? acc_wdata : 16'h0000);
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wd);
        check("cpu_stall", cpu_stall, cpu_req && !c_win);
        check("acc_gnt", acc_gnt, a_win);
        check("cpu_rvalid", cpu_rvalid, pend_owner == 1);
        check("cpu_rdata", cpu_rdata, (pend_owner == 1) ? pend_data : 16'h0000);
        check("acc_rvalid", acc_rvalid, pend_owner == 2);
        check("acc_rdata", acc_rdata, (pend_owner == 2) ? pend_data : 16'h0000);
        check("one_rvalid", cpu_rvalid && acc_rvalid, 1'b0);
        pend_owner = 0;
        if (e_en && !e_we) begin
            pend_owner = c_win ? 1 : 2;
            pend_data  = ref_mem[e_addr[7:0]];
        end
        if (e_en && e_we) ref_mem[e_addr[7:0]] = e_wd;
        if (acc_req && !a_win) waited = (waited >= SM) ? SM : waited + 1;
        else waited = 0;
        last_cpu_win = c_win;
        last_acc_win = a_win;
    endtask

    // Drive inputs just after a falling edge and check the combinational response.
    task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                         input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        acc_req = ar; acc_we = aw; acc_addr = aa; acc_wdata = ad;
        #1;
        check_cycle();
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        adv();
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b0; pl_en = 1'b0; pl_addr = 8'h00; pl_data = 16'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        acc_req = 1'b0; acc_we = 1'b0; acc_addr = 16'h0000; acc_wdata = 16'h0000;
        model_reset();
        // preload memory while reset is held
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v = (i == 16'h10) ? 16'hBEEF : (i == 2) ? 16'h1111 : (i == 4) ? 16'h2222 : 16'(i * 16'h0101 + 16'h0033);
            pl_en = 1'b1; pl_addr = 8'(i); pl_data = v; ref_mem[i] = v;
        end
        @(negedge clk);
        pl_en = 1'b0;
        cpu_req = 1'b1; acc_req = 1'b1;
        #1;
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_gnt", acc_gnt, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_rvalid", cpu_rvalid || acc_rvalid, 1'b0);
        cpu_req = 1'b0; acc_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle();

        // CPU-only read
        drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("cpu_only_stall", cpu_stall, 1'b0);
        adv();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("cpu_only_rvalid", cpu_rvalid, 1'b1);
        check("cpu_only_rdata", cpu_rdata, 16'hBEEF);
        adv();

        // Contention: CPU four cycles, then the accelerator
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000);
            check("cont_gnt", acc_gnt, (i == 4) ? 1'b1 : 1'b0);
            check("cont_stall", cpu_stall, (i == 4) ? 1'b1 : 1'b0);
            adv();
        end
        drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000);
        check("cont_restart", acc_gnt, 1'b0);
        check("cont_rdata_acc", acc_rdata, 16'h2222);
        adv();
        idle(); idle();

        // Alternating owners back to back
        drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000); adv();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000);
        check("alt_cpu_rdata", cpu_rdata, 16'h1111);
        check("alt_acc_quiet", acc_rvalid, 1'b0);
        adv();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("alt_acc_rdata", acc_rdata, 16'h2222);
        check("alt_cpu_quiet", cpu_rvalid, 1'b0);
        adv();

        // Accelerator write then CPU read of the same word
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hA5A5); adv();
        drive(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("wr_no_rvalid", acc_rvalid || cpu_rvalid, 1'b0);
        adv();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("wr_rd_data", cpu_rdata, 16'hA5A5);
        adv();

        // Accelerator backs off at count 3: counter restarts
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000); adv();
        end
        drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h0000); adv();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000);
            check("drop_gnt", acc_gnt, (i == 4) ? 1'b1 : 1'b0);
            adv();
        end
        idle();

        // Reset while a CPU read is in flight
        drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_stall", cpu_stall, 1'b0);
        check("mid_rst_mem_en", mem_en, 1'b0);
        check("mid_rst_addr", mem_addr, 16'h0000);
        @(posedge clk); #1;
        check("mid_rst_rvalid", cpu_rvalid, 1'b0);
        check("mid_rst_rdata", cpu_rdata, 16'h0000);
        @(negedge clk);
        cpu_req = 1'b0;
        rst = 1'b1;
        model_reset();
        idle();

        // Randomized traffic; ungranted requests are held stable
        last_cpu_win = 1'b1; last_acc_win = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic cr, cw, ar, aw;
            logic [15:0] ca, cd, aa, ad;
            cr = cpu_req; cw = cpu_we; ca = cpu_addr; cd = cpu_wdata;
            ar = acc_req; aw = acc_we; aa = acc_addr; ad = acc_wdata;
            if (!cpu_req || last_cpu_win) begin
                cr = ($urandom_range(0, 9) < 7); cw = $urandom_range(0, 1) == 1;
                ca = 16'($urandom_range(0, 31)); cd = 16'($urandom);
            end
            if (!acc_req || last_acc_win) begin
                ar = ($urandom_range(0, 9) < 6); aw = $urandom_range(0, 1) == 1;
                aa = 16'($urandom_range(0, 31)); ad = 16'($urandom);
            end
            drive(cr, cw, ca, cd, ar, aw, aa, ad);
            adv();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
